// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter sequencing N byte requesters onto one SPI master
module spi_txn_arbiter #(
  parameter int N = 2,
  parameter int TIMEOUT = 1024,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] wdata,
  output logic [N-1:0]   ack,
  output logic [7:0]     rdata,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic           fault,
  output logic           m_start,
  output logic [7:0]     m_data_in,
  input  logic [7:0]     m_data_out,
  input  logic           m_done
);
  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, RELEASE, FAULT} state_t;
  state_t state, state_n;
  logic [IW-1:0] last, win;
  logic [IW:0] j;
  logic [CW-1:0] cnt;
  logic found;
  always_comb begin
    win = '0;
    found = 1'b0;
    j = '0;
    for (int i = 1; i <= N; i++) begin
      j = {1'b0, last} + (IW+1)'(i);
      j = (j >= (IW+1)'(N)) ? j - (IW+1)'(N) : j;
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        win = j[IW-1:0];
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = found ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = m_done ? CAPTURE : (cnt == CW'(TIMEOUT - 1)) ? FAULT : WAIT;
      CAPTURE: state_n = RELEASE;
      RELEASE: state_n = m_done ? RELEASE : IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= IW'(N - 1);
      grant_id <= '0;
      m_data_in <= '0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        last <= win;
        grant_id <= win;
        m_data_in <= wdata[{win, 3'b000} +: 8];
      end
      if (state == WAIT && m_done) rdata <= m_data_out;
    end
  end
  assign m_start = state == START;
  assign busy = state != IDLE;
  assign fault = state == FAULT;
  assign ack = (state == CAPTURE) ? N'(1) << grant_id : '0;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed and randomized self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] wdata = '0;
  logic [N-1:0] ack;
  logic [7:0] rdata;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out = '0;
  logic [1:0] grant_id;
  logic busy;
  logic fault;
  logic m_start;
  logic m_done = 1'b0;
  int checks = 0;
  int failures = 0;
  bit dead = 1'b0;
  int fix_lat = 0;
  int fix_resp = -1;
  int lat = 0;
  int hold = 0;
  bit pend = 1'b0;
  bit s_rst = 1'b1;
  bit s_done = 1'b0;
  logic [N-1:0] s_req = '0;
  logic [8*N-1:0] s_wdata = '0;
  logic [7:0] s_dout = '0;
  int e = 0;
  bit act = 1'b0;
  bit mf = 1'b0;
  bit mvalid = 1'b0;
  int mlast = N - 1;
  int gid = 0;
  int g = -1000;
  int jd = -1;
  logic [7:0] mbyte = '0;
  logic [7:0] mrd = '0;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .grant_id(grant_id),
    .busy(busy),
    .fault(fault),
    .m_start(m_start),
    .m_data_in(m_data_in),
    .m_data_out(m_data_out),
    .m_done(m_done)
  );

  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_done = 1'b0;
      pend = 1'b0;
      hold = 0;
    end else if (m_start) begin
      pend = !dead;
      lat = fix_lat > 0 ? fix_lat : ($urandom_range(0, 3) == 0 ? TO : int'($urandom_range(1, TO)));
      m_done = !dead && $urandom_range(0, 3) == 0;
      m_data_out = 8'($urandom);
      hold = 0;
    end else if (pend) begin
      lat--;
      m_done = lat == 0;
      if (lat == 0) begin
        m_data_out = fix_resp >= 0 ? 8'(fix_resp) : 8'($urandom);
        pend = 1'b0;
        hold = $urandom_range(0, 1) == 1 ? 1 : int'($urandom_range(1, 4));
      end
    end else if (hold > 0) begin
      hold--;
      m_done = hold != 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_and_compare();
    int w;
    int x;
    forever begin
      @(negedge clk);
      e++;
      if (s_rst) begin
        act = 1'b0;
        mf = 1'b0;
        mlast = N - 1;
        gid = 0;
        mbyte = '0;
        mrd = '0;
        jd = -1;
        mvalid = 1'b1;
      end else if (mvalid && !mf) begin
        if (!act) begin
          if (s_req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
              x = (mlast + k) % N;
              if (w < 0 && s_req[x[1:0]]) w = x;
            end
            gid = w;
            mlast = w;
            mbyte = 8'(s_wdata >> (8 * w));
            act = 1'b1;
            g = e;
            jd = -1;
          end
        end else if (jd < 0) begin
          if (e >= g + 2 && s_done) begin
            jd = e;
            mrd = s_dout;
          end else if (e == g + 1 + TO) begin
            mf = 1'b1;
          end
        end else if (e >= jd + 2 && !s_done) begin
          act = 1'b0;
        end
      end
      if (mvalid) begin
        chk("busy", 32'(busy), 32'(act || mf));
        chk("fault", 32'(fault), 32'(mf));
        chk("m_start", 32'(m_start), 32'(act && e == g));
        chk("ack", 32'(ack), (act && jd == e) ? 32'(1) << gid : 32'(0));
        chk("rdata", 32'(rdata), 32'(mrd));
        chk("grant_id", 32'(grant_id), 32'(gid));
        if (act) chk("m_data_in", 32'(m_data_in), 32'(mbyte));
      end
      s_rst = rst;
      s_req = req;
      s_wdata = wdata;
      s_done = m_done;
      s_dout = m_data_out;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc(1);
      ok = m_start;
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc(1);
      ok = |ack;
    end
  endtask

  initial begin
    bit ok;
    int n;
    int na;
    fork
      model_and_compare();
    join_none
    cyc(3);
    rst = 1'b0;
    fix_resp = 'h3C;
    fix_lat = 5;
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    wait_start(ok);
    chk("A_start_seen", 32'(ok), 32'd1);
    chk("A_data", 32'(m_data_in), 32'hA5);
    chk("A_gid", 32'(grant_id), 32'd0);
    wait_ack(ok);
    chk("A_ack_seen", 32'(ok), 32'd1);
    chk("A_ack", 32'(ack), 32'h1);
    chk("A_rdata", 32'(rdata), 32'h3C);
    req = '0;
    cyc(6);
    chk("A_idle", 32'(busy), 32'd0);
    do_reset();
    wdata[15:0] = 16'h5AA5;
    req = 4'b0011;
    for (int t = 0; t < 2; t++) begin
      wait_start(ok);
      chk("B_start_seen", 32'(ok), 32'd1);
      chk("B_data", 32'(m_data_in), t == 0 ? 32'hA5 : 32'h5A);
      wait_ack(ok);
      chk("B_ack", 32'(ack), 32'(1) << t);
      req = req & ~(4'(1) << t);
    end
    cyc(8);
    do_reset();
    req = '1;
    for (int t = 0; t < 12; t++) begin
      wait_ack(ok);
      chk("C_ack_seen", 32'(ok), 32'd1);
      chk("C_gid", 32'(grant_id), 32'(t % 4));
    end
    req = '0;
    cyc(8);
    do_reset();
    fix_lat = 10;
    wdata = 32'h44337711;
    req = 4'b0001;
    wait_start(ok);
    chk("D_start_seen", 32'(ok), 32'd1);
    cyc(1);
    req[1] = 1'b1;
    cyc(2);
    req[1] = 1'b0;
    cyc(1);
    req[0] = 1'b0;
    wait_ack(ok);
    chk("D_late_drop_ack", 32'(ack), 32'h1);
    n = 0;
    repeat (20) begin
      cyc(1);
      n += int'(m_start);
    end
    chk("D_withdrawn_starts", 32'(n), 32'd0);
    dead = 1'b1;
    do_reset();
    req = 4'b0001;
    wait_start(ok);
    chk("E_start_seen", 32'(ok), 32'd1);
    n = 0;
    na = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      cyc(1);
      n++;
      na += int'(|ack);
    end
    chk("E_latency", 32'(n), 32'd17);
    chk("E_noack", 32'(na), 32'd0);
    chk("E_busy", 32'(busy), 32'd1);
    cyc(5);
    chk("E_sticky", 32'(fault), 32'd1);
    dead = 1'b0;
    do_reset();
    chk("E_fault_clr", 32'(fault), 32'd0);
    req = 4'b0001;
    wait_start(ok);
    chk("E2_start_seen", 32'(ok), 32'd1);
    wait_ack(ok);
    chk("E2_ack", 32'(ack), 32'h1);
    chk("E2_rdata", 32'(rdata), 32'h3C);
    req = '0;
    cyc(6);
    req = 4'b0100;
    wait_start(ok);
    chk("F_gid", 32'(grant_id), 32'd2);
    cyc(3);
    rst = 1'b1;
    req = '0;
    cyc(1);
    rst = 1'b0;
    chk("F_ack", 32'(ack), 32'd0);
    chk("F_rdata", 32'(rdata), 32'd0);
    chk("F_gid_rst", 32'(grant_id), 32'd0);
    chk("F_busy", 32'(busy), 32'd0);
    chk("F_fault", 32'(fault), 32'd0);
    chk("F_m_start", 32'(m_start), 32'd0);
    chk("F_m_data_in", 32'(m_data_in), 32'd0);
    req = 4'b1010;
    wait_start(ok);
    chk("F_first_gid", 32'(grant_id), 32'd1);
    chk("F_first_data", 32'(m_data_in), 32'h77);
    wait_ack(ok);
    chk("F_ack1", 32'(ack), 32'h2);
    chk("F_rdata1", 32'(rdata), 32'h3C);
    req = 4'b1000;
    wait_ack(ok);
    chk("F_gid3", 32'(grant_id), 32'd3);
    req = '0;
    cyc(6);
    fix_lat = 0;
    fix_resp = -1;
    for (int c = 0; c < 2500; c++) begin
      cyc(1);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req[i[1:0]] && (ack[i[1:0]] || $urandom_range(0, 39) == 0)) begin
          req[i[1:0]] = 1'b0;
        end else if (!req[i[1:0]] && $urandom_range(0, 3) == 0) begin
          req[i[1:0]] = 1'b1;
          wdata[{i[1:0], 3'b000} +: 8] = 8'($urandom);
        end
      end
      if (busy && $urandom_range(0, 3) == 0) wdata[{grant_id, 3'b000} +: 8] = 8'($urandom);
    end
    req = '0;
    cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and sequencer that shares one `spi_master_fsm` between `N` independent requesters. It accepts one byte-transfer request per requester and issues a single-cycle `start` to the master with the winner's byte. It waits for the master's `done`, then returns the received byte and a one-cycle acknowledge to the winner. It sits between client logic (config/readout engines) and the SPI master, so no client drives the master directly.

## Interface
- `N`, 2: number of requesters (2..8).
- `TIMEOUT`, 1024: max clocks from `m_start` to `m_done` before fault (≥ 16).
- `clk`  in  1  system clock, same clock as the SPI master.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester transfer request (level).
- `wdata`  in  8*N  byte for requester i in bits [8i+7:8i].
- `ack`  out  N  one-cycle completion pulse to the served requester.
- `rdata`  out  8  received byte; valid in the `ack` cycle, held until the next completion.
- `grant_id`  out  clog2(N)  index of the requester currently or last served.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  sticky timeout flag.
- `m_start`  out  1  start pulse to the SPI master.
- `m_data_in`  out  8  byte to transmit, to master `data_in`.
- `m_data_out`  in  8  master received byte.
- `m_done`  in  1  master completion (pulse or level).

## Operation
- States: IDLE, START, WAIT, CAPTURE, RELEASE, FAULT.
- **IDLE.** If any `req` bit is high, select the winner round-robin.
  - The search starts at `(last+1) mod N`; `last` resets to N-1, so requester 0 wins first after reset.
  - Latch the winner's index into `grant_id`/`last` and its `wdata` byte into `m_data_in`.
  - Go to START.
- **START.** `m_start`=1 for exactly this cycle; `m_data_in` is stable from START through RELEASE. Go to WAIT.
- **WAIT.**
  - Count clocks.
  - `m_done`=1 → register `m_data_out` into `rdata`, go to CAPTURE.
  - Count reaching TIMEOUT without `m_done` → go to FAULT.
  - `m_done` is never sampled in START, so a stale level from the previous transfer is ignored.
- **CAPTURE.** `ack[grant_id]`=1 for one cycle. Go to RELEASE.
- **RELEASE.** Wait for `m_done`=0, then go to IDLE. If `m_done` is already low, this takes exactly one cycle.
- **FAULT.**
  - `fault`=1, `busy`=1; `m_start` stays 0 and no `ack` is issued.
  - Exit only via `rst`. The faulted requester never receives an `ack`.
- **Requester rules.**
  - Hold `req` and `wdata` until `ack`.
  - Dropping `req` before the grant withdraws the request.
  - Dropping `req` after the grant is ignored; the transfer completes and `ack` still pulses.
  - Changes to `wdata` after the IDLE latch have no effect.
- Ties are resolved only by rotation; there is no fixed priority. With all N requesting continuously, each is served once per N transfers.
- **Reset values:** state IDLE, `ack`=0, `rdata`=8'h00, `grant_id`=0, `last`=N-1, `busy`=0, `fault`=0, `m_start`=0, `m_data_in`=8'h00, timeout counter 0.
- **Reset mid-transfer:** all state is discarded, no `ack` is issued, and reset values apply the next cycle. The master is reset by the same `rst`.

## Timing
- `req` sampled high in IDLE at edge k:
  - START (`m_start`=1) during cycle k+1.
  - WAIT from k+2.
- `m_done` sampled high at edge j in WAIT:
  - `ack` and `rdata` valid during cycle j+1.
  - RELEASE at j+2.
  - IDLE at j+3 if `m_done` is low.
- Back-to-back requests:
  - The next `m_start` comes no earlier than 2 cycles after RELEASE exits.
  - Arbitration overhead is 4 cycles beyond the master's transfer time.
- Timeout: FAULT is entered at the edge where the WAIT counter reaches TIMEOUT. A `m_done` arriving in that same cycle wins, and the transfer completes normally.
- `busy` rises the cycle after the IDLE→START decision and falls on return to IDLE.

## Test plan
- **Single request.** N=2, SPI slave model returns 8'h3C; `req`=2'b01, `wdata[7:0]`=8'hA5.
  - One `m_start` pulse with `m_data_in`=A5.
  - `ack`=2'b01 for one cycle with `rdata`=3C.
  - `grant_id`=0; `busy` falls afterwards.
- **Simultaneous requests.** `req`=2'b11 from reset, `wdata`={8'h5A,8'hA5}.
  - Requester 0 is served first (`m_data_in`=A5), then requester 1 (5A).
  - Exactly one `ack` per requester; no overlapping `m_start`.
- **Fairness.** N=4, all `req` held high for 12 transfers → `grant_id` sequence is 0,1,2,3 repeated three times.
- **Withdrawal and late drop.**
  - Requester 1 raises then drops `req` while requester 0 is being served → requester 1 is never started.
  - Requester 0 drops `req` during WAIT → its `ack` still pulses.
- **Timeout.** TIMEOUT=16, `m_done` tied low.
  - `fault` rises 16 clocks after entering WAIT; no `ack`; `busy` stays 1.
  - `rst` clears `fault`, and the next request completes normally.
- **Reset mid-transfer.** Assert `rst` for 1 cycle during WAIT.
  - The next cycle shows all reset values with no `ack`.
  - A following request from requester 1 starts with requester 0 as highest priority and completes correctly.
